// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the PS/2 set-2 key event decoder
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } parse_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_PGUP  = 8'h02;
  localparam logic [7:0] ASCII_PGDN  = 8'h03;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_HOME  = 8'h0D;
  localparam logic [7:0] ASCII_UP    = 8'h11;
  localparam logic [7:0] ASCII_LEFT  = 8'h12;
  localparam logic [7:0] ASCII_DOWN  = 8'h13;
  localparam logic [7:0] ASCII_RIGHT = 8'h14;
  localparam logic [7:0] ASCII_END   = 8'h17;
  localparam logic [7:0] ASCII_INS   = 8'h1A;
  localparam logic [7:0] ASCII_DEL   = 8'h7F;

  // Letters are the only keys whose case follows caps lock.
  function automatic logic is_letter(input logic [7:0] code);
    case (code)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/scan_xlate.sv
// rtl/scan_xlate.sv - combinational set-2 scan code to US-layout ASCII translation
// Unmapped codes, including bare keypad codes, yield NUL.
module scan_xlate
  import key_pkg::*;
(
  input  logic [7:0] code,
  input  logic       upper,
  input  logic       extended,
  output logic [7:0] ascii
);

  logic [15:0] pair;  // {shifted glyph, unshifted glyph}

  always_comb begin
    pair = {ASCII_NUL, ASCII_NUL};
    if (extended) begin
      case (code)
        8'h75:   pair = {2{ASCII_UP}};
        8'h6B:   pair = {2{ASCII_LEFT}};
        8'h72:   pair = {2{ASCII_DOWN}};
        8'h74:   pair = {2{ASCII_RIGHT}};
        8'h6C:   pair = {2{ASCII_HOME}};
        8'h7D:   pair = {2{ASCII_PGUP}};
        8'h7A:   pair = {2{ASCII_PGDN}};
        8'h69:   pair = {2{ASCII_END}};
        8'h71:   pair = {2{ASCII_DEL}};
        8'h70:   pair = {2{ASCII_INS}};
        default: pair = {ASCII_NUL, ASCII_NUL};
      endcase
    end else begin
      case (code)
        8'h1C: pair = "Aa";
        8'h32: pair = "Bb";
        8'h21: pair = "Cc";
        8'h23: pair = "Dd";
        8'h24: pair = "Ee";
        8'h2B: pair = "Ff";
        8'h34: pair = "Gg";
        8'h33: pair = "Hh";
        8'h43: pair = "Ii";
        8'h3B: pair = "Jj";
        8'h42: pair = "Kk";
        8'h4B: pair = "Ll";
        8'h3A: pair = "Mm";
        8'h31: pair = "Nn";
        8'h44: pair = "Oo";
        8'h4D: pair = "Pp";
        8'h15: pair = "Qq";
        8'h2D: pair = "Rr";
        8'h1B: pair = "Ss";
        8'h2C: pair = "Tt";
        8'h3C: pair = "Uu";
        8'h2A: pair = "Vv";
        8'h1D: pair = "Ww";
        8'h22: pair = "Xx";
        8'h35: pair = "Yy";
        8'h1A: pair = "Zz";
        8'h45: pair = ")0";
        8'h16: pair = "!1";
        8'h1E: pair = "@2";
        8'h26: pair = "#3";
        8'h25: pair = "$4";
        8'h2E: pair = "%5";
        8'h36: pair = "^6";
        8'h3D: pair = "&7";
        8'h3E: pair = "*8";
        8'h46: pair = "(9";
        8'h0E: pair = {8'h7E, 8'h60};
        8'h4E: pair = "_-";
        8'h55: pair = "+=";
        8'h5D: pair = {8'h7C, 8'h5C};
        8'h54: pair = "{[";
        8'h5B: pair = "}]";
        8'h4C: pair = ":;";
        8'h52: pair = {8'h22, 8'h27};
        8'h41: pair = "<,";
        8'h49: pair = ">.";
        8'h4A: pair = "?/";
        8'h29: pair = "  ";
        8'h5A: pair = {2{ASCII_LF}};
        8'h66: pair = {2{ASCII_BS}};
        8'h0D: pair = {2{ASCII_TAB}};
        default: pair = {ASCII_NUL, ASCII_NUL};
      endcase
    end
    ascii = upper ? pair[15:8] : pair[7:0];
  end

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - PS/2 set-2 byte parser with modifier tracking and FWFT ASCII queue
module key_event_decoder
  import key_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_FILTER = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scan_valid,
  input  logic [7:0]                  scan_code,
  output logic                        ascii_valid,
  input  logic                        ascii_ready,
  output logic [7:0]                  ascii_code,
  output logic                        shift_held,
  output logic                        caps_lock,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  parse_state_e state_q, state_d;
  logic         lshift_q, lshift_d, rshift_q, rshift_d;
  logic         caps_q, caps_d, caps_held_q, caps_held_d;
  logic         ovf_q, ovf_d;
  logic [8:0]   last_make_q, last_make_d;
  logic         last_ok_q, last_ok_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_q, count_d;
  logic [7:0]   mem_q [FIFO_DEPTH];

  logic       is_make, is_break, ext, is_mod, upper, repeat_hit;
  logic       push, push_ok, pop, full;
  logic [7:0] xl_ascii;

  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    ext      = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_BRK)      state_d = ST_BRK;
          else if (scan_code == SC_EXT) state_d = ST_EXT;
          else                          is_make = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == SC_BRK) state_d = ST_EXT_BRK;
          else begin
            is_make = 1'b1;
            ext     = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_break = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_break = 1'b1;
          ext      = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // E0-prefixed 12/59 belong to fake-shift sequences, so only plain codes count as modifiers.
  assign is_mod = !ext && (scan_code == SC_LSHIFT || scan_code == SC_RSHIFT || scan_code == SC_CAPS);

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if ((is_make || is_break) && !ext) begin
      if (scan_code == SC_LSHIFT) lshift_d = is_make;
      if (scan_code == SC_RSHIFT) rshift_d = is_make;
      if (scan_code == SC_CAPS) begin
        caps_held_d = is_make;
        if (is_make && !caps_held_q) caps_d = !caps_q;
      end
    end
  end

  assign shift_held = lshift_q | rshift_q;
  assign caps_lock  = caps_q;
  assign upper      = is_letter(scan_code) ? (shift_held ^ caps_q) : shift_held;

  scan_xlate u_xlate (
    .code     (scan_code),
    .upper    (upper),
    .extended (ext),
    .ascii    (xl_ascii)
  );

  assign repeat_hit = (REPEAT_FILTER != 0) && last_ok_q && (last_make_q == {ext, scan_code});
  assign push       = is_make && !is_mod && (xl_ascii != ASCII_NUL) && !repeat_hit;
  assign full       = count_q[AW];
  assign pop        = ascii_valid && ascii_ready;
  assign push_ok    = push && (!full || pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    last_make_d = last_make_q;
    last_ok_d   = last_ok_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    if (push && !push_ok) ovf_d = 1'b1;
    if (is_break) last_ok_d = 1'b0;
    if (push_ok) begin
      last_make_d = {ext, scan_code};
      last_ok_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      ovf_q       <= 1'b0;
      last_make_q <= '0;
      last_ok_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      ovf_q       <= ovf_d;
      last_make_q <= last_make_d;
      last_ok_q   <= last_ok_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= xl_ascii;
  end

  assign ascii_valid = (count_q != '0);
  assign ascii_code  = ascii_valid ? mem_q[rd_ptr_q] : ASCII_NUL;
  assign overflow    = ovf_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - directed self-checking bench for key_event_decoder
module tb_key_event_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, sv_a, rdy_a, av_a, sh_a, cl_a, ov_a;
  logic [7:0] sc_a, ac_a;
  logic [2:0] cnt_a;
  logic       rst_b, sv_b, rdy_b, av_b, sh_b, cl_b, ov_b;
  logic [7:0] sc_b, ac_b;
  logic [3:0] cnt_b;

  int checks = 0;
  int failures = 0;

  key_event_decoder #(.FIFO_DEPTH(4), .REPEAT_FILTER(0)) dut_a (
    .clk(clk), .reset(rst_a), .scan_valid(sv_a), .scan_code(sc_a),
    .ascii_valid(av_a), .ascii_ready(rdy_a), .ascii_code(ac_a),
    .shift_held(sh_a), .caps_lock(cl_a), .overflow(ov_a), .fifo_count(cnt_a)
  );

  key_event_decoder #(.FIFO_DEPTH(8), .REPEAT_FILTER(1)) dut_b (
    .clk(clk), .reset(rst_b), .scan_valid(sv_b), .scan_code(sc_b),
    .ascii_valid(av_b), .ascii_ready(rdy_b), .ascii_code(ac_b),
    .shift_held(sh_b), .caps_lock(cl_b), .overflow(ov_b), .fifo_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit to_b, input logic [7:0] c);
    @(negedge clk);
    if (to_b) begin sv_b = 1'b1; sc_b = c; end
    else      begin sv_a = 1'b1; sc_a = c; end
    @(negedge clk);
    sv_a = 1'b0;
    sv_b = 1'b0;
  endtask

  task automatic pop(input bit to_b);
    @(negedge clk);
    if (to_b) rdy_b = 1'b1;
    else      rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; sv_a = 1'b0; rdy_a = 1'b0; sc_a = 8'h00;
    rst_b = 1'b1; sv_b = 1'b0; rdy_b = 1'b0; sc_b = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(av_a), 0);
    check("rst_code", 32'(ac_a), 8'h00);
    check("rst_count", 32'(cnt_a), 0);
    check("rst_shift", 32'(sh_a), 0);
    check("rst_caps", 32'(cl_a), 0);
    check("rst_ovf", 32'(ov_a), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    send(0, 8'h1C);
    check("make_a_valid", 32'(av_a), 1);
    check("make_a_code", 32'(ac_a), 8'h61);
    send(0, 8'hF0); send(0, 8'h1C);
    check("break_a_count", 32'(cnt_a), 1);
    pop(0);
    check("pop_a_count", 32'(cnt_a), 0);

    send(0, 8'h12);
    check("shift_held", 32'(sh_a), 1);
    send(0, 8'h1C);
    check("shift_A", 32'(ac_a), 8'h41);
    check("shift_no_enq", 32'(cnt_a), 1);
    pop(0);
    send(0, 8'hF0); send(0, 8'h12);
    check("shift_released", 32'(sh_a), 0);
    send(0, 8'h1C);
    check("unshift_a", 32'(ac_a), 8'h61);
    pop(0);

    send(0, 8'h58);
    check("caps_on", 32'(cl_a), 1);
    send(0, 8'h58);
    check("caps_repeat_held", 32'(cl_a), 1);
    check("caps_no_enq", 32'(cnt_a), 0);
    send(0, 8'hF0); send(0, 8'h58);
    send(0, 8'h12); send(0, 8'h1C);
    check("caps_shift_a", 32'(ac_a), 8'h61);
    pop(0);
    send(0, 8'hF0); send(0, 8'h12);
    send(0, 8'h1C);
    check("caps_A", 32'(ac_a), 8'h41);
    pop(0);
    send(0, 8'h12); send(0, 8'h16);
    check("shift_bang", 32'(ac_a), 8'h21);
    pop(0);
    send(0, 8'hF0); send(0, 8'h12);
    send(0, 8'h16);
    check("caps_digit_1", 32'(ac_a), 8'h31);
    pop(0);
    send(0, 8'h58); send(0, 8'hF0); send(0, 8'h58);
    check("caps_off", 32'(cl_a), 0);

    send(0, 8'hE0); send(0, 8'h75);
    check("ext_up", 32'(ac_a), 8'h11);
    pop(0);
    send(0, 8'h75);
    check("bare_kp8", 32'(cnt_a), 0);
    send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h75);
    check("ext_break", 32'(cnt_a), 0);
    send(0, 8'hE0); send(0, 8'h71);
    check("ext_del", 32'(ac_a), 8'h7F);
    pop(0);
    send(0, 8'h29);
    check("space", 32'(ac_a), 8'h20);
    pop(0);

    send(0, 8'h1C); send(0, 8'h32); send(0, 8'h21); send(0, 8'h23);
    check("full_count", 32'(cnt_a), 4);
    check("full_no_ovf", 32'(ov_a), 0);
    send(0, 8'h24);
    check("ovf_count", 32'(cnt_a), 4);
    check("ovf_flag", 32'(ov_a), 1);
    check("ovf_head", 32'(ac_a), 8'h61);
    @(negedge clk);
    sv_a = 1'b1; sc_a = 8'h1C; rdy_a = 1'b1;
    @(negedge clk);
    sv_a = 1'b0; rdy_a = 1'b0;
    check("pushpop_full_count", 32'(cnt_a), 4);
    check("pushpop_head", 32'(ac_a), 8'h62);
    pop(0);
    check("drain_c", 32'(ac_a), 8'h63);
    pop(0);
    check("drain_d", 32'(ac_a), 8'h64);
    pop(0);
    check("drain_wrapped_a", 32'(ac_a), 8'h61);
    pop(0);
    check("drain_empty", 32'(av_a), 0);
    check("ovf_sticky", 32'(ov_a), 1);
    send(0, 8'h1C); send(0, 8'h1C);
    check("nofilter_repeat", 32'(cnt_a), 2);

    send(1, 8'h1C); send(1, 8'h1C); send(1, 8'h1C);
    send(1, 8'hF0); send(1, 8'h1C);
    send(1, 8'h1C); send(1, 8'h1C);
    check("filter_count", 32'(cnt_b), 2);
    check("filter_head", 32'(ac_b), 8'h61);
    send(1, 8'hE0);
    #2 rst_b = 1'b1;
    #1;
    check("async_rst_count", 32'(cnt_b), 0);
    check("async_rst_valid", 32'(av_b), 0);
    @(negedge clk);
    rst_b = 1'b0;
    send(1, 8'h75);
    check("rst_after_e0", 32'(cnt_b), 0);
    send(1, 8'h1C);
    check("filter_mem_cleared", 32'(cnt_b), 1);
    check("filter_mem_head", 32'(ac_b), 8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning output queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter REPEAT_FILTER, default 0, meaning 1 = drop typematic repeat makes.
REQ-003 SHALL have port clk, input, 1, meaning the sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port scan_valid, input, 1, meaning one received PS/2 byte per asserted cycle.
REQ-006 SHALL have port scan_code, input, 8, meaning the raw PS/2 set-2 byte.
REQ-007 SHALL have port ascii_valid, output, 1, meaning the queue head is valid.
REQ-008 SHALL have port ascii_ready, input, 1, meaning consumer accepts the head.
REQ-009 SHALL have port ascii_code, output, 8, meaning the queue head character.
REQ-010 SHALL have port shift_held, output, 1, meaning left or right shift is down.
REQ-011 SHALL have port caps_lock, output, 1, meaning caps lock latch state.
REQ-012 SHALL have port overflow, output, 1, meaning sticky flag: a character was dropped on a full queue.
REQ-013 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning the current queue occupancy.

Function
REQ-014 Parser FSM SHALL have states IDLE, BRK, EXT, EXT_BRK.
- IDLE: F0->BRK; E0->EXT; other->make, stay IDLE.
- EXT: F0->EXT_BRK; other->extended make, then IDLE.
- BRK and EXT_BRK: any byte->break of that code, then IDLE.
REQ-015 SHALL track left and right shift independently: 0x12/0x59 make sets, break clears; shift_held is their OR; shift bytes never enqueue.
REQ-016 SHALL toggle caps_lock on a 0x58 make only when caps is not already held; repeated 0x58 makes while held SHALL NOT toggle; 0x58 never enqueues.
REQ-017 Letters (a-z) SHALL use uppercase when shift_held XOR caps_lock; all other printable keys SHALL use shifted glyphs iff shift_held.
REQ-018 Mapping:
- Printable, space, LF, BS and TAB SHALL use standard US layout.
- Navigation codes SHALL translate only after E0: up 0x11, left 0x12, down 0x13, right 0x14, home 0x0D, pgup 0x02, pgdn 0x03, end 0x17, del 0x7F, ins 0x1A.
- The same codes without E0 (keypad) SHALL map to NUL.
REQ-019 Break events, NUL results and unknown codes SHALL NOT enqueue.
REQ-020 With REPEAT_FILTER=1, a make equal to the last enqueued make with no intervening break SHALL be dropped; with REPEAT_FILTER=0 every make enqueues.
REQ-021 Latency: scan_valid in cycle N with an empty queue SHALL give ascii_valid=1 with the code in cycle N+1.
REQ-022 Queue SHALL be first-word-fall-through: a pop occurs on ascii_valid&&ascii_ready, and ascii_code SHALL hold stable while ascii_valid=1 and ascii_ready=0.
REQ-023 Push and pop in the same cycle SHALL both occur at any occupancy, including full; fifo_count is then unchanged.
REQ-024 A push on a full queue without a pop SHALL drop the character and set overflow, which stays set until reset.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL reach FIFO_DEPTH exactly.

Reset
REQ-026 Reset SHALL force, asynchronously:
- FSM to IDLE;
- shift_held, caps_lock, overflow and ascii_valid to 0;
- ascii_code to 0x00 and fifo_count to 0;
- repeat-filter memory cleared.
REQ-027 Reset mid-sequence (for example after E0) SHALL discard the partial sequence; the first byte after reset is parsed from IDLE.

Structure
REQ-028 Package key_pkg SHALL hold the FSM state enum, the prefix constants (0xE0, 0xF0), the shift/caps scan codes and the ASCII control-code constants.
REQ-029 The translation table SHALL be a combinational sub-module scan_xlate, with inputs code, upper and extended, and output ascii.

Verification
REQ-030 Scenarios the bench SHALL cover:
- 1C then F0 1C -> one entry 0x61, fifo_count 1, nothing on break.
- 12, 1C, F0 12, 1C -> 0x41 then 0x61.
- 58, F0 58, then 1C with shift -> 0x61; caps_lock=1.
- E0 75 -> 0x11. Bare 75 -> nothing. E0 F0 75 -> nothing.
- FIFO_DEPTH=4, ascii_ready=0, 5 makes -> fifo_count 4, overflow=1, head equals the first code; then simultaneous push+pop on full -> count stays 4.
- REPEAT_FILTER=1: 1C 1C 1C F0 1C 1C -> exactly two 0x61. Reset asserted after E0 -> a following 75 yields nothing.
